// File: rtl/hm01b0_pixel_source.sv
// hm01b0 pixel-bus transmitter: streams a stored frame with sensor timing.
// Optional build macro: HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN (synthetic pixels).
module hm01b0_pixel_source #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int ADDR_W  = 17,
  parameter int CLK_DIV = 2,
  parameter int H_BLANK = 16,
  parameter int V_LEAD  = 8,
  parameter int V_TAIL  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              hm01b0_pixclk,
  output logic [7:0]        hm01b0_pixdata,
  output logic              hm01b0_hsync,
  output logic              hm01b0_vsync
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int CW = 16;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_VLEAD, S_LINE, S_HBLANK, S_VTAIL
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              pclk_q, pclk_d;
  logic [7:0]        pix_q, pix_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wrap, rise, tick, latch;
  logic [7:0]        src;

`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
  logic [7:0] fc_q, fc_d;
  logic       unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign src = 8'(x_d) + 8'(y_d) + fc_q;
`else
  assign src = mem_rdata;
`endif

  assign wrap = busy_q && (div_q == DW'(CLK_DIV - 1));
  assign rise = wrap && !pclk_q;
  assign tick = wrap && pclk_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pclk_d  = pclk_q;
    pix_d   = pix_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    raddr_d = raddr_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
    fc_d    = fc_q;
`endif
    if (busy_q) begin
      div_d = wrap ? '0 : div_q + 1'b1;
      if (wrap) pclk_d = !pclk_q;
    end
`ifndef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
    if (rise) raddr_d = addr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          busy_d  = 1'b1;
          div_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_VLEAD;
          vs_d    = 1'b1;
          cnt_d   = '0;
          addr_d  = '0;
        end
      end
      S_VLEAD: begin
        if (tick) begin
          if (cnt_q == CW'(V_LEAD - 1)) begin
            state_d = S_LINE;
            x_d     = '0;
            y_d     = '0;
            hs_d    = 1'b1;
            latch   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LINE: begin
        if (tick) begin
          if (x_q == XW'(WIDTH - 1)) begin
            hs_d    = 1'b0;
            pix_d   = '0;
            cnt_d   = '0;
            state_d = (y_q == YW'(HEIGHT - 1)) ? S_VTAIL : S_HBLANK;
          end else begin
            x_d   = x_q + 1'b1;
            latch = 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (tick) begin
          if (cnt_q == CW'(H_BLANK - 1)) begin
            state_d = S_LINE;
            x_d     = '0;
            y_d     = y_q + 1'b1;
            hs_d    = 1'b1;
            latch   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_VTAIL: begin
        if (tick) begin
          if (cnt_q == CW'(V_TAIL - 1)) begin
            vs_d    = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
            raddr_d = '0;
`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
            fc_d    = fc_q + 1'b1;
`endif
            if (continuous) begin
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // address always points at the next pixel to fetch; parks on the last one
    if (latch) begin
      pix_d = src;
`ifndef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
      if (addr_q != LAST) addr_d = addr_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      pclk_q  <= 1'b0;
      pix_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      raddr_q <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
      fc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      raddr_q <= raddr_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
      fc_q    <= fc_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign mem_raddr      = raddr_q;
  assign hm01b0_pixclk  = pclk_q;
  assign hm01b0_pixdata = pix_q;
  assign hm01b0_hsync   = hs_q;
  assign hm01b0_vsync   = vs_q;

endmodule

// File: tb/tb_hm01b0_pixel_source.sv
// Bench for hm01b0_pixel_source: per-rise bus samples against a frame model.
// Small geometry so whole frames, resets and continuous runs fit quickly.
module tb_hm01b0_pixel_source;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 8;
  localparam int CD = 2;
  localparam int HB = 2;
  localparam int VL = 3;
  localparam int VT = 1;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset, start, continuous;
  logic          busy, frame_done;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata;
  logic          pixclk;
  logic [7:0]    pixdata;
  logic          hsync, vsync;

  logic [7:0] mem [NPIX];

  hm01b0_pixel_source #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .CLK_DIV(CD),
    .H_BLANK(HB), .V_LEAD(VL), .V_TAIL(VT)
  ) dut (
    .clock(clk), .reset(reset), .start(start),
    .continuous(continuous), .busy(busy),
    .frame_done(frame_done), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .hm01b0_pixclk(pixclk),
    .hm01b0_pixdata(pixdata), .hm01b0_hsync(hsync),
    .hm01b0_vsync(vsync)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    mem_rdata <= mem[mem_raddr[2:0]];

  typedef struct {
    int nf;
    bit spam;
    int lines;
    int frames;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int fc_model = 0;
  int exp_q[$];
  int got_q[$];
  int rise_t[$];
  int done_busy[$];
  int cyc_n, hs_cnt, vs_cnt, done_cnt;
  bit prev_pc, prev_hs, prev_vs, prev_done;

  function automatic int pack(bit v, bit h, int pd, int a);
    return (int'(v) << 17) | (int'(h) << 16) | ((pd & 255) << 8) | (a & 255);
  endfunction

  task automatic chk(string name, int got, int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  function automatic int pix(int x, int y, int fc);
`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
    return (x + y + fc) % 256;
`else
    return int'(mem[y * W + x]);
`endif
  endfunction

  function automatic int adr(int n);
`ifdef HM01B0_PIXEL_SOURCE_TEST_PATTERN_EN
    return 0;
`else
    return (n < NPIX - 1) ? n : NPIX - 1;
`endif
  endfunction

  // Expected bus state at every pixclk rise of one frame.
  task automatic model_frame();
    int n = 0;
    exp_q.push_back(pack(0, 0, 0, 0));
    repeat (VL) exp_q.push_back(pack(1, 0, 0, 0));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n++;
        exp_q.push_back(pack(1, 1, pix(x, y, fc_model), adr(n)));
      end
      if (y < H - 1)
        repeat (HB) exp_q.push_back(pack(1, 0, 0, adr(n)));
    end
    repeat (VT) exp_q.push_back(pack(1, 0, 0, adr(n)));
    fc_model++;
  endtask

  task automatic clear_mon();
    exp_q.delete();
    got_q.delete();
    rise_t.delete();
    done_busy.delete();
    hs_cnt = 0;
    vs_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (pixclk && !prev_pc) begin
      got_q.push_back(pack(vsync, hsync, pixdata, mem_raddr));
      rise_t.push_back(cyc_n);
    end
    if (hsync && !prev_hs) hs_cnt++;
    if (vsync && !prev_vs) vs_cnt++;
    if (prev_done) done_busy.push_back(busy);
    if (frame_done) done_cnt++;
    prev_pc = pixclk;
    prev_hs = hsync;
    prev_vs = vsync;
    prev_done = frame_done;
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".pixclk"}, pixclk, 0);
    chk({tag, ".pixdata"}, pixdata, 0);
    chk({tag, ".hsync"}, hsync, 0);
    chk({tag, ".vsync"}, vsync, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, frame_done, 0);
    chk({tag, ".raddr"}, mem_raddr, 0);
  endtask

  task automatic run(vec_t v, string tag);
    int bad = 0;
    bit fin = 0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    clear_mon();
    repeat (v.nf) model_frame();
    continuous = (v.nf > 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < 4000 && !fin; t++) begin
      cyc();
      if (done_cnt >= v.nf - 1) continuous = 1'b0;
      start = v.spam && busy && ($urandom_range(0, 4) == 0);
      fin = (done_cnt == v.nf) && !busy;
    end
    start = 1'b0;
    cyc();
    chk({tag, ".finished"}, int'(fin), 1);
    chk({tag, ".rises"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.rise[%0d]", tag, i), got_q[i], exp_q[i]);
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != 2 * CD) bad++;
    chk({tag, ".period"}, bad, 0);
    chk({tag, ".hsync_pulses"}, hs_cnt, v.lines);
    chk({tag, ".vsync_pulses"}, vs_cnt, v.frames);
    chk({tag, ".frame_done"}, done_cnt, v.frames);
    chk({tag, ".done_busy_n"}, done_busy.size(), v.frames);
    for (int i = 0; i < done_busy.size(); i++)
      chk($sformatf("%s.busy_after_done[%0d]", tag, i),
          done_busy[i], (i < v.nf - 1) ? 1 : 0);
  endtask

  vec_t tbl[5];

  initial begin
    bit hit;
    tbl[0] = '{nf: 1, spam: 0, lines: 2, frames: 1};
    tbl[1] = '{nf: 1, spam: 1, lines: 2, frames: 1};
    tbl[2] = '{nf: 3, spam: 0, lines: 6, frames: 3};
    tbl[3] = '{nf: 2, spam: 1, lines: 4, frames: 2};
    tbl[4] = '{nf: 3, spam: 1, lines: 6, frames: 3};
    cyc_n = 0;
    prev_pc = 0;
    prev_hs = 0;
    prev_vs = 0;
    prev_done = 0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(8'h10 + i);
    reset = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    repeat (3) cyc();
    check_zero("reset");
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++)
      run(tbl[i], $sformatf("vec%0d", i));

    // Reset while driving line 1 pixel x=2, then a clean frame.
    clear_mon();
    start = 1'b1;
    cyc();
    start = 1'b0;
    hit = 0;
    for (int t = 0; t < 400 && !hit; t++) begin
      cyc();
      hit = (got_q.size() == 1 + VL + W + HB + 3);
    end
    chk("midreset.reached", int'(hit), 1);
    chk("midreset.hsync_before", hsync, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    prev_pc = pixclk;
    prev_hs = hsync;
    prev_vs = vsync;
    prev_done = frame_done;
    fc_model = 0;
    repeat (4) cyc();
    check_zero("midreset.idle");
    run(tbl[0], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
